// File: rtl/ifm_pingpong_buffer.sv
// Two-bank ping-pong feature-map buffer between a producing and a consuming layer; optional IFM_BUF_PROTECT_EN guards full banks.
// Latency: reads return data one cycle after enable; start_to_next rises two cycles after start_from_previous.
// Backpressure: none; the producer waits for end_to_previous before reusing a bank, and the consumer paces release with end_from_next.
module ifm_pingpong_buffer #(
    parameter int DATA_WIDTH       = 32,
    parameter int IFM_SIZE         = 14,
    parameter int ADDRESS_SIZE_IFM = $clog2(IFM_SIZE*IFM_SIZE)
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        ifm_enable_write,
    input  logic [ADDRESS_SIZE_IFM-1:0] ifm_address_write,
    input  logic                        ifm_sel_write,
    input  logic [DATA_WIDTH-1:0]       data_in,
    input  logic                        start_from_previous,
    output logic                        end_to_previous,
    input  logic                        ifm_enable_read_A,
    input  logic [ADDRESS_SIZE_IFM-1:0] ifm_address_read_A,
    input  logic                        ifm_enable_read_B,
    input  logic [ADDRESS_SIZE_IFM-1:0] ifm_address_read_B,
    output logic [DATA_WIDTH-1:0]       data_out_A,
    output logic [DATA_WIDTH-1:0]       data_out_B,
    output logic                        start_to_next,
    input  logic                        end_from_next,
    output logic                        overflow_err
);

    localparam int DEPTH = IFM_SIZE * IFM_SIZE;
    localparam logic [ADDRESS_SIZE_IFM:0] DEPTH_W = (ADDRESS_SIZE_IFM+1)'(DEPTH);

    typedef enum logic [1:0] {S_IDLE, S_START, S_BUSY, S_RELEASE} state_t;

    state_t                r_state;
    state_t                w_state_nxt;
    logic [1:0]            r_full;
    logic                  r_rd_bank;
    logic [DATA_WIDTH-1:0] r_mem [2][DEPTH];

    logic w_wr_in_range;
    logic w_rd_in_range_A;
    logic w_rd_in_range_B;
    logic w_wr_ok;
    logic w_sfp_ok;
    logic w_release;

    assign w_wr_in_range   = {1'b0, ifm_address_write}  < DEPTH_W;
    assign w_rd_in_range_A = {1'b0, ifm_address_read_A} < DEPTH_W;
    assign w_rd_in_range_B = {1'b0, ifm_address_read_B} < DEPTH_W;
    assign w_release       = (r_state == S_RELEASE);

`ifdef IFM_BUF_PROTECT_EN
    // A bank still owned by the consumer must not be touched by the producer.
    logic r_overflow;

    assign w_wr_ok  = ifm_enable_write && w_wr_in_range && !r_full[ifm_sel_write];
    assign w_sfp_ok = start_from_previous && !r_full[ifm_sel_write];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_overflow <= 1'b0;
        end else if ((ifm_enable_write || start_from_previous) && r_full[ifm_sel_write]) begin
            r_overflow <= 1'b1;
        end
    end

    assign overflow_err = r_overflow;
`else
    assign w_wr_ok      = ifm_enable_write && w_wr_in_range;
    assign w_sfp_ok     = start_from_previous;
    assign overflow_err = 1'b0;
`endif

    // Bank storage is deliberately left unreset.
    always_ff @(posedge clk) begin
        if (w_wr_ok) begin
            r_mem[ifm_sel_write][ifm_address_write] <= data_in;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            data_out_A <= '0;
            data_out_B <= '0;
        end else begin
            if (ifm_enable_read_A) begin
                data_out_A <= w_rd_in_range_A ? r_mem[r_rd_bank][ifm_address_read_A] : '0;
            end
            if (ifm_enable_read_B) begin
                data_out_B <= w_rd_in_range_B ? r_mem[r_rd_bank][ifm_address_read_B] : '0;
            end
        end
    end

    // Release clears the reader's bank; a same-edge fill of the other bank is kept.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_full    <= 2'b00;
            r_rd_bank <= 1'b0;
            r_state   <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
            if (w_release) begin
                r_full[r_rd_bank] <= 1'b0;
                r_rd_bank         <= ~r_rd_bank;
            end
            if (w_sfp_ok) begin
                r_full[ifm_sel_write] <= 1'b1;
            end
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:    if (r_full[r_rd_bank]) w_state_nxt = S_START;
            S_START:   w_state_nxt = S_BUSY;
            S_BUSY:    if (end_from_next) w_state_nxt = S_RELEASE;
            S_RELEASE: w_state_nxt = S_IDLE;
            default:   w_state_nxt = S_IDLE;
        endcase
    end

    assign start_to_next   = (r_state == S_START);
    assign end_to_previous = w_release;

endmodule

// File: doc/ifm_pingpong_buffer.md
IFM_PINGPONG_BUFFER -- requirements
Module: ifm_pingpong_buffer

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, word width.
REQ-002 SHALL have parameter IFM_SIZE, default 14, feature-map side; bank depth = IFM_SIZE*IFM_SIZE words.
REQ-003 SHALL have derived parameter ADDRESS_SIZE_IFM = $clog2(IFM_SIZE*IFM_SIZE).
REQ-004 SHALL have ports, clock and reset first:
  clk  input  1  single clock, all logic on rising edge
  reset  input  1  asynchronous, active-low reset
  ifm_enable_write  input  1  write strobe from producing layer
  ifm_address_write  input  ADDRESS_SIZE_IFM  write address
  ifm_sel_write  input  1  bank selected by producer (0 = bank 0, 1 = bank 1)
  data_in  input  DATA_WIDTH  write data
  start_from_previous  input  1  one-cycle pulse: producer finished bank ifm_sel_write
  end_to_previous  output  1  one-cycle pulse: a bank was released to producer
  ifm_enable_read_A  input  1  read strobe, port A
  ifm_address_read_A  input  ADDRESS_SIZE_IFM  read address, port A
  ifm_enable_read_B  input  1  read strobe, port B
  ifm_address_read_B  input  ADDRESS_SIZE_IFM  read address, port B
  data_out_A  output  DATA_WIDTH  read data, port A
  data_out_B  output  DATA_WIDTH  read data, port B
  start_to_next  output  1  one-cycle pulse: bank ready for consumer
  end_from_next  input  1  one-cycle pulse: consumer finished current bank
  overflow_err  output  1  sticky protocol-error flag (see Configuration)

Function
REQ-005 SHALL hold two banks of IFM_SIZE*IFM_SIZE words, each with one full flag.
REQ-006 ifm_enable_write=1 SHALL write data_in to bank ifm_sel_write at ifm_address_write on that edge.
REQ-007 start_from_previous=1 SHALL set full flag of bank ifm_sel_write on that edge.
REQ-008 Reader pointer rd_bank SHALL select the bank both read ports access; reset value 0.
REQ-009 Reads SHALL be synchronous: data_out_X valid one cycle after ifm_enable_read_X=1; data_out_X SHALL hold its value while enable is low.
REQ-010 Ports A and B SHALL read simultaneously, including the same address, returning identical data.
REQ-011 Reader FSM states: IDLE, START, BUSY, RELEASE.
REQ-012 IDLE -> START when full flag of rd_bank is set; start_to_next=1 only in START (exactly one cycle).
REQ-013 START -> BUSY unconditionally.
REQ-014 BUSY -> RELEASE on end_from_next=1; end_from_next in other states SHALL be ignored.
REQ-015 RELEASE SHALL clear full flag of rd_bank, toggle rd_bank, assert end_to_previous for exactly that cycle, then -> IDLE.
REQ-016 Latency: start_from_previous at edge N with reader in IDLE on rd_bank SHALL give start_to_next high in cycle N+2.
REQ-017 Same-edge start_from_previous (setting bank X) and RELEASE (clearing bank Y != X) SHALL both take effect.
REQ-018 If both banks are full at RELEASE, FSM SHALL return to START for the other bank two cycles after end_to_previous.
REQ-019 Address >= IFM_SIZE*IFM_SIZE: writes SHALL be dropped; reads SHALL return 0.

Reset
REQ-020 reset=0 SHALL immediately clear full flags, rd_bank=0, FSM=IDLE, start_to_next=0, end_to_previous=0, data_out_A=data_out_B=0, overflow_err=0.
REQ-021 Bank memory contents SHALL NOT be reset; reset mid-BUSY discards ownership, and the next transfer begins from bank 0.

Configuration
REQ-022 Macro IFM_BUF_PROTECT_EN defined: writes or start_from_previous targeting a bank whose full flag is set SHALL be dropped and set overflow_err (sticky until reset).
REQ-023 Macro undefined: such writes SHALL proceed, start_from_previous on a full bank SHALL have no extra effect, and overflow_err SHALL be tied 0.

Verification
REQ-024 Write bank 0 addr k with k+100 for all k, pulse start_from_previous (sel 0) -> start_to_next two cycles later; read A addr 5 -> data_out_A=105 next cycle.
REQ-025 Ports A addr 0 and B addr 195 together (IFM_SIZE=14) -> data_out_A=100, data_out_B=295 same cycle.
REQ-026 Fill bank 0 and bank 1, pulse end_from_next -> end_to_previous one cycle, rd_bank=1, start_to_next two cycles after end_to_previous.
REQ-027 With IFM_BUF_PROTECT_EN, write 0xDEAD into full bank 0 addr 3 -> overflow_err=1, addr 3 still reads 103; without macro -> reads 0xDEAD, overflow_err=0.
REQ-028 Assert reset=0 in BUSY -> all outputs 0 immediately; after release, refill bank 0 -> normal handshake resumes.
REQ-029 end_from_next in IDLE -> ignored, no end_to_previous.
